// File: rtl/lsu_mem_if.sv
// LSU data-port bundle: pipeline request/response plus the data-RAM side.
// master = lsu_mem_master, slave = pipeline/memory environment.
interface lsu_mem_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic [1:0]  resp_err_o;
    logic        ce_o;
    logic [3:0]  sel_o;
    logic [31:0] addr_o;
    logic        we_o;
    logic [31:0] data_o;
    logic        rvalid_i;
    logic [31:0] data_i;

    modport master (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output ce_o, sel_o, addr_o, we_o, data_o,
        input  rvalid_i, data_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  ce_o, sel_o, addr_o, we_o, data_o,
        output rvalid_i, data_i
    );
endinterface

// File: rtl/lsu_mem_master.sv
// LSU data-port initiator: lane-aligns loads/stores, splits misaligned
// accesses into two word accesses and merges/extends the read data.
module lsu_mem_master #(
    parameter int unsigned TIMEOUT  = 15,
    parameter bit          SPLIT_EN = 1'b1
) (
    input  logic      clk_i,
    input  logic      n_rst_i,
    lsu_mem_if.master bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned WW = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC1 = 2'd1;
    localparam logic [1:0] S_ACC2 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            ready_q, ready_d;
    logic            we_q, we_d;
    logic            uns_q, uns_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      off_q, off_d;
    logic [29:0]     waddr_q, waddr_d;
    logic [7:0]      lanes_q, lanes_d;
    logic [2*DW-1:0] wd_q, wd_d;
    logic [DW-1:0]   lo_q, lo_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            resp_valid_q, resp_valid_d;
    logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]      resp_err_q, resp_err_d;

    logic [3:0]      req_mask;
    logic [1:0]      req_off;
    logic [7:0]      req_lanes;
    logic [2*DW-1:0] req_wd;
    logic            req_mis;
    logic            acc_done;

    // Shift the merged pair down to the access offset, then extend per size.
    function automatic logic [DW-1:0] load_result(input logic [2*DW-1:0] r64,
                                                  input logic [1:0] off,
                                                  input logic [1:0] size,
                                                  input logic uns);
        logic [DW-1:0] r;
        logic [DW-1:0] res;
        r = DW'(r64 >> {off, 3'b000});
        case (size)
            2'd0:    res = uns ? {24'b0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
            2'd1:    res = uns ? {16'b0, r[15:0]} : {{16{r[15]}}, r[15:0]};
            default: res = r;
        endcase
        return res;
    endfunction

    // Lane/data placement of the incoming request, used only when latching it.
    always_comb begin
        case (bus.req_size_i)
            2'd0:    req_mask = 4'h1;
            2'd1:    req_mask = 4'h3;
            default: req_mask = 4'hF;
        endcase
        req_off   = bus.req_addr_i[1:0];
        req_lanes = {4'b0, req_mask} << req_off;
        req_wd    = {32'b0, bus.req_wdata_i} << {req_off, 3'b000};
        req_mis   = |req_lanes[7:4];
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        uns_d        = uns_q;
        size_d       = size_q;
        off_d        = off_q;
        waddr_d      = waddr_q;
        lanes_d      = lanes_q;
        wd_d         = wd_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        wait_d       = wait_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 2'b00;
        acc_done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ready_q && bus.req_valid_i) begin
                    we_d    = bus.req_we_i;
                    uns_d   = bus.req_unsigned_i;
                    size_d  = bus.req_size_i;
                    off_d   = req_off;
                    waddr_d = bus.req_addr_i[31:2];
                    lanes_d = req_lanes;
                    wd_d    = req_wd;
                    lo_d    = '0;
                    hi_d    = '0;
                    wait_d  = '0;
                    if (req_mis && !SPLIT_EN) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 2'b01;
                    end else begin
                        state_d = S_ACC1;
                    end
                end
            end
            S_ACC1, S_ACC2: begin
                if (we_q) begin
                    acc_done = 1'b1;
                end else if (bus.rvalid_i) begin
                    if (state_q == S_ACC2) hi_d = bus.data_i;
                    else                   lo_d = bus.data_i;
                    acc_done = 1'b1;
                end else if (wait_q == WW'(TIMEOUT)) begin
                    state_d      = S_RESP;
                    wait_d       = '0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 2'b10;
                end else begin
                    wait_d = wait_q + WW'(1);
                end

                if (acc_done) begin
                    wait_d = '0;
                    if (state_q == S_ACC1 && (|lanes_q[7:4])) begin
                        state_d = S_ACC2;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = we_q ? '0 : load_result({hi_d, lo_d}, off_q, size_q, uns_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            waddr_q      <= '0;
            lanes_q      <= '0;
            wd_q         <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            wait_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            we_q         <= we_d;
            uns_q        <= uns_d;
            size_q       <= size_d;
            off_q        <= off_d;
            waddr_q      <= waddr_d;
            lanes_q      <= lanes_d;
            wd_q         <= wd_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            wait_q       <= wait_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Memory side decoded from state and latched fields only; the second
    // word address wraps naturally through the 30-bit word index.
    always_comb begin
        bus.ce_o   = 1'b0;
        bus.we_o   = 1'b0;
        bus.sel_o  = 4'b0;
        bus.addr_o = '0;
        bus.data_o = '0;
        if (state_q == S_ACC1) begin
            bus.ce_o   = 1'b1;
            bus.we_o   = we_q;
            bus.sel_o  = lanes_q[3:0];
            bus.addr_o = {waddr_q, 2'b00};
            bus.data_o = wd_q[DW-1:0];
        end else if (state_q == S_ACC2) begin
            bus.ce_o   = 1'b1;
            bus.we_o   = we_q;
            bus.sel_o  = lanes_q[7:4];
            bus.addr_o = {waddr_q + 30'd1, 2'b00};
            bus.data_o = wd_q[2*DW-1:DW];
        end
    end

    assign bus.req_ready_o  = ready_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_rdata_o = resp_rdata_q;
    assign bus.resp_err_o   = resp_err_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: split-enabled and split-disabled
// instances driven from shared request fields, memory modelled by a lookup.
module tb_lsu_mem_master;
    logic clk;
    logic n_rst;

    logic        valid0, valid1;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rvalid_en;
    logic [31:0] mem_a0, mem_d0, mem_a1, mem_d1;

    int tests;
    int failed;
    int resp_cnt0;
    bit ce1_seen;
    int ce_cnt;

    lsu_mem_if bus0();
    lsu_mem_if bus1();

    lsu_mem_master #(.TIMEOUT(15), .SPLIT_EN(1'b1)) u_dut0 (
        .clk_i   (clk),
        .n_rst_i (n_rst),
        .bus     (bus0)
    );

    lsu_mem_master #(.TIMEOUT(15), .SPLIT_EN(1'b0)) u_dut1 (
        .clk_i   (clk),
        .n_rst_i (n_rst),
        .bus     (bus1)
    );

    assign bus0.req_valid_i    = valid0;
    assign bus0.req_we_i       = req_we;
    assign bus0.req_size_i     = req_size;
    assign bus0.req_unsigned_i = req_uns;
    assign bus0.req_addr_i     = req_addr;
    assign bus0.req_wdata_i    = req_wdata;
    assign bus0.rvalid_i       = rvalid_en & bus0.ce_o & ~bus0.we_o;
    assign bus0.data_i         = (bus0.addr_o == mem_a0) ? mem_d0 :
                                 (bus0.addr_o == mem_a1) ? mem_d1 : 32'hDEAD_BEEF;

    assign bus1.req_valid_i    = valid1;
    assign bus1.req_we_i       = req_we;
    assign bus1.req_size_i     = req_size;
    assign bus1.req_unsigned_i = req_uns;
    assign bus1.req_addr_i     = req_addr;
    assign bus1.req_wdata_i    = req_wdata;
    assign bus1.rvalid_i       = 1'b0;
    assign bus1.data_i         = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus0.resp_valid_o) resp_cnt0++;
        if (bus1.ce_o) ce1_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in cycle 1 after acceptance.
    task automatic issue(input bit which, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        req_we    = we;
        req_size  = size;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wdata;
        if (which) begin
            valid1 = 1'b1;
            check("ready1_at_issue", 32'(bus1.req_ready_o), 32'h1);
        end else begin
            valid0 = 1'b1;
            check("ready0_at_issue", 32'(bus0.req_ready_o), 32'h1);
        end
        tick();
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        resp_cnt0 = 0;
        ce1_seen  = 1'b0;
        n_rst     = 1'b0;
        valid0    = 1'b0;
        valid1    = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'd0;
        req_uns   = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rvalid_en = 1'b0;
        mem_a0    = 32'h0;
        mem_d0    = 32'h0;
        mem_a1    = 32'h1;
        mem_d1    = 32'h0;

        tick();
        tick();
        check("rst_ready", 32'(bus0.req_ready_o), 32'h0);
        check("rst_resp_valid", 32'(bus0.resp_valid_o), 32'h0);
        check("rst_ce", 32'(bus0.ce_o), 32'h0);
        check("rst_addr", bus0.addr_o, 32'h0);
        n_rst = 1'b1;
        tick();
        check("post_rst_ready", 32'(bus0.req_ready_o), 32'h1);

        // Store byte 0xAB to 0x102
        issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0102, 32'h0000_00AB);
        check("sb_ce", 32'(bus0.ce_o), 32'h1);
        check("sb_we", 32'(bus0.we_o), 32'h1);
        check("sb_sel", 32'(bus0.sel_o), 32'h4);
        check("sb_addr", bus0.addr_o, 32'h0000_0100);
        check("sb_data", bus0.data_o, 32'h00AB_0000);
        check("sb_ready_busy", 32'(bus0.req_ready_o), 32'h0);
        tick();
        check("sb_resp_valid", 32'(bus0.resp_valid_o), 32'h1);
        check("sb_rdata", bus0.resp_rdata_o, 32'h0);
        check("sb_err", 32'(bus0.resp_err_o), 32'h0);
        check("sb_ce_off", 32'(bus0.ce_o), 32'h0);
        tick();
        check("sb_resp_done", 32'(bus0.resp_valid_o), 32'h0);

        // Load half from 0x102, signed then unsigned
        mem_a0 = 32'h0000_0100; mem_d0 = 32'h80F1_0000; rvalid_en = 1'b1;
        issue(1'b0, 1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0);
        check("lh_sel", 32'(bus0.sel_o), 32'hC);
        check("lh_we", 32'(bus0.we_o), 32'h0);
        tick();
        check("lh_resp_valid", 32'(bus0.resp_valid_o), 32'h1);
        check("lh_rdata", bus0.resp_rdata_o, 32'hFFFF_80F1);
        check("lh_err", 32'(bus0.resp_err_o), 32'h0);
        tick();
        issue(1'b0, 1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0);
        tick();
        check("lhu_rdata", bus0.resp_rdata_o, 32'h0000_80F1);
        tick();

        // Load byte signed from 0x101 (byte 0x9C)
        mem_d0 = 32'h0000_9C00;
        issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0);
        check("lb_sel", 32'(bus0.sel_o), 32'h2);
        tick();
        check("lb_rdata", bus0.resp_rdata_o, 32'hFFFF_FF9C);
        tick();

        // Split store word 0x11223344 to 0x1003
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_1003, 32'h1122_3344);
        check("sw1_addr", bus0.addr_o, 32'h0000_1000);
        check("sw1_sel", 32'(bus0.sel_o), 32'h8);
        check("sw1_data", bus0.data_o, 32'h4400_0000);
        tick();
        check("sw2_ce", 32'(bus0.ce_o), 32'h1);
        check("sw2_addr", bus0.addr_o, 32'h0000_1004);
        check("sw2_sel", 32'(bus0.sel_o), 32'h7);
        check("sw2_data", bus0.data_o, 32'h0011_2233);
        check("sw2_no_resp", 32'(bus0.resp_valid_o), 32'h0);
        tick();
        check("sw_resp_valid", 32'(bus0.resp_valid_o), 32'h1);
        check("sw_err", 32'(bus0.resp_err_o), 32'h0);
        tick();

        // Split load word across the address wrap
        mem_a0 = 32'hFFFF_FFFC; mem_d0 = 32'hAAAA_0000;
        mem_a1 = 32'h0000_0000; mem_d1 = 32'h0000_BBBB;
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0);
        check("lw_wrap_a1", bus0.addr_o, 32'hFFFF_FFFC);
        check("lw_wrap_s1", 32'(bus0.sel_o), 32'hC);
        tick();
        check("lw_wrap_a2", bus0.addr_o, 32'h0000_0000);
        check("lw_wrap_s2", 32'(bus0.sel_o), 32'h3);
        tick();
        check("lw_wrap_valid", 32'(bus0.resp_valid_o), 32'h1);
        check("lw_wrap_rdata", bus0.resp_rdata_o, 32'hBBBB_AAAA);
        tick();
        mem_a1 = 32'h1; mem_d1 = 32'h0;

        // Timeout: rvalid never comes
        rvalid_en = 1'b0;
        ce_cnt = 0;
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0);
        for (int i = 0; i < 16; i++) begin
            if (bus0.ce_o) ce_cnt++;
            tick();
        end
        check("to_ce_cycles", 32'(ce_cnt), 32'd16);
        check("to_resp_valid", 32'(bus0.resp_valid_o), 32'h1);
        check("to_err", 32'(bus0.resp_err_o), 32'h2);
        check("to_rdata", bus0.resp_rdata_o, 32'h0);
        tick();

        // rvalid arrives on the last tolerated wait cycle
        mem_a0 = 32'h0000_0300; mem_d0 = 32'h1234_5678;
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        rvalid_en = 1'b1;
        #1;
        check("late_ce", 32'(bus0.ce_o), 32'h1);
        check("late_no_resp", 32'(bus0.resp_valid_o), 32'h0);
        tick();
        check("late_resp_valid", 32'(bus0.resp_valid_o), 32'h1);
        check("late_err", 32'(bus0.resp_err_o), 32'h0);
        check("late_rdata", bus0.resp_rdata_o, 32'h1234_5678);
        tick();

        // Misaligned word load rejected when splitting is disabled
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0);
        check("rej_resp_valid", 32'(bus1.resp_valid_o), 32'h1);
        check("rej_err", 32'(bus1.resp_err_o), 32'h1);
        check("rej_rdata", bus1.resp_rdata_o, 32'h0);
        tick();
        check("rej_ready_back", 32'(bus1.req_ready_o), 32'h1);
        check("rej_ce_never", 32'(ce1_seen), 32'h0);

        // Reset during ACC2 of a split store
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_1003, 32'h1122_3344);
        tick();
        check("rst_mid_acc2", 32'(bus0.sel_o), 32'h7);
        resp_cnt0 = 0;
        n_rst = 1'b0;
        tick();
        check("rst_mid_ce", 32'(bus0.ce_o), 32'h0);
        check("rst_mid_ready", 32'(bus0.req_ready_o), 32'h0);
        n_rst = 1'b1;
        tick();
        check("rst_mid_ready_back", 32'(bus0.req_ready_o), 32'h1);
        tick();
        check("rst_mid_no_resp", 32'(resp_cnt0), 32'h0);

        mem_a0 = 32'h0000_0400; mem_d0 = 32'hCAFE_F00D;
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0);
        check("post_ld_addr", bus0.addr_o, 32'h0000_0400);
        tick();
        check("post_ld_valid", 32'(bus0.resp_valid_o), 32'h1);
        check("post_ld_rdata", bus0.resp_rdata_o, 32'hCAFE_F00D);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Initiator side of the LSU data port that the on-chip data RAM answers on. It accepts one load/store request at a time from the pipeline and generates the byte-lane select, word address and lane-aligned write data. It splits misaligned accesses into two word accesses, then merges and sign/zero-extends read data before returning a single response. It sits between the MEM stage and the data RAM / bus arbiter.

## Interface
- TIMEOUT, 15: read wait-state cycles tolerated before a timeout error (1..255).
- SPLIT_EN, 1: 1 = misaligned accesses are split into two accesses; 0 = misaligned accesses are rejected with an error.
- clk_i  in  1  clock, all logic on the rising edge.
- n_rst_i  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request; 1 only in IDLE.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-justified.
- resp_valid_o  out  1  one-cycle response strobe.
- resp_rdata_o  out  32  extended load data; 0 for stores and errors.
- resp_err_o  out  2  bit0 = misaligned rejected, bit1 = read timeout.
- ce_o  out  1  memory chip enable.
- sel_o  out  4  byte-lane enables; sel_o[i] covers data bits 8i+7:8i.
- addr_o  out  32  word address, bits 1:0 always 0.
- we_o  out  1  memory write enable.
- data_o  out  32  lane-aligned write data.
- rvalid_i  in  1  read data valid, same cycle as ce_o=1 and we_o=0.
- data_i  in  32  read data, combinational from memory.

## Operation
- States: IDLE, ACC1, ACC2, RESP.
- IDLE: req_ready_o=1. On req_valid_i, latch the request and compute the following; then go to ACC1, or straight to RESP on error.
  - off = addr[1:0]; nbytes = 1/2/4; mask = 1/3/F.
  - lanes64 = {4'b0,mask} << off; wd64 = {32'b0,wdata} << 8*off.
  - misaligned = lanes64[7:4] != 0.
  - If misaligned and SPLIT_EN=0: no memory access; go to RESP with err=01.
- ACC1: ce_o=1, we_o=req_we, addr_o={addr[31:2],2'b00}, sel_o=lanes64[3:0], data_o=wd64[31:0].
- ACC2 (misaligned only): addr_o = ACC1 address + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); sel_o=lanes64[7:4]; data_o=wd64[63:32].
- Store: each ACC state lasts exactly one cycle; rvalid_i is ignored.
- Load: sample data_i into lo (ACC1) or hi (ACC2) in the cycle rvalid_i=1.
  - While rvalid_i=0, stay in the state with outputs held and increment an 8-bit wait counter.
  - When the counter reaches TIMEOUT with rvalid_i still 0, go to RESP with err=10 and rdata=0.
  - The wait counter clears on every state change.
- Load result: r64={hi,lo} >> 8*off. Take the low nbytes bytes, then extend from bit 7/15 (sign or zero, per req_unsigned_i). Words pass through unchanged.
- RESP: resp_valid_o=1 for one cycle with resp_rdata_o/resp_err_o, then go to IDLE. A new request is accepted in IDLE at the earliest.
- Memory outputs outside ACC states: ce_o=0, we_o=0, sel_o=0, addr_o=0, data_o=0.
- Reset (n_rst_i=0 at a clock edge): state goes to IDLE and every output is 0 except req_ready_o, which is 1 from the first cycle after reset.
  - Reset mid-operation abandons the request with no response.
  - The first half of a split store that already completed is not rolled back.

## Timing
- Request accepted at edge N (cycle 0). ACC1 drives the memory in cycle 1.
- Aligned access, no wait states: resp_valid_o in cycle 2.
- Split access: ACC2 in cycle 2, resp_valid_o in cycle 3.
- Each read wait state adds one cycle. A timeout response comes TIMEOUT+2 cycles after accept for ACC1.
- Rejected misaligned access (SPLIT_EN=0): resp_valid_o in cycle 1.
- Throughput: one request per 3 cycles (aligned), 4 cycles (split).
- All outputs are registered, except memory outputs, which are decoded from registered state and latched request fields with no combinational path from req_*.

## Test plan
- Store byte 0xAB to 0x102 -> ACC1 shows sel_o=0100, addr_o=0x100, data_o=0x00AB0000, we_o=1; resp_valid_o 2 cycles after accept, rdata 0, err 0.
- Load half signed from 0x102, memory word 0x80F1_0000 -> sel_o=1100, resp_rdata_o=0xFFFF80F1; with req_unsigned_i=1 -> 0x000080F1.
- Store word 0x11223344 to 0x1003 -> ACC1: addr 0x1000, sel 1000, data 0x44000000. ACC2: addr 0x1004, sel 0111, data 0x00112233. resp_valid_o in cycle 3.
- Load word from 0xFFFF_FFFE with words 0xAAAA_0000 then 0x0000_BBBB -> ACC2 addr_o=0x0000_0000; resp_rdata_o=0xBBBBAAAA.
- Load word, rvalid_i held 0, TIMEOUT=15 -> ce_o held for 16 cycles, then resp_err_o=10, resp_rdata_o=0; with SPLIT_EN=0, a word load at 0x2 -> ce_o never 1, err=01 in cycle 1.
- Assert n_rst_i=0 during ACC2 of a split store -> next cycle ce_o=0, req_ready_o=0, resp_valid_o never pulses; after release, req_ready_o=1 and a new aligned load completes normally.
